// File: rtl/ctrl_pipe_reg.sv
// Pipeline register for decoded control bundles between core stages.
// Holds on a data-cache stall, loads a NOP bubble on flush, and flags reset/flush contents.
module ctrl_pipe_reg #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  NOP_VAL = '0,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bubble
);

  logic [WIDTH-1:0] ctrl_q = RST_VAL;
  logic [WIDTH-1:0] ctrl_d;
  logic             bubble_q = 1'b1;
  logic             bubble_d;

  // A flush request seen while stalled is dropped; only an enabled edge can act on clr.
  always_comb begin
    ctrl_d   = ctrl_q;
    bubble_d = bubble_q;
    if (en) begin
      if (clr) begin
        ctrl_d   = NOP_VAL;
        bubble_d = 1'b1;
      end else begin
        ctrl_d   = d;
        bubble_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= RST_VAL;
      bubble_q <= 1'b1;
    end else begin
      ctrl_q   <= ctrl_d;
      bubble_q <= bubble_d;
    end
  end

  assign q      = ctrl_q;
  assign bubble = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// Self-checking bench for ctrl_pipe_reg: single stages plus a shrinking four-stage chain.
// Expected {bubble,q} words are queued as stimulus is applied and popped after each edge.
module tb_ctrl_pipe_reg;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       bub;
    logic [7:0] q;
  } vec_t;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        clr;
    logic [7:0]  d;
    logic [29:0] exp;
  } chainVec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] d     = 8'h00;
  logic [7:0] q;
  logic       bubble;
  logic [7:0] qNop;
  logic       bubbleNop;

  logic       cReset = 1'b1;
  logic       cEn    = 1'b0;
  logic       cClr   = 1'b0;
  logic [7:0] cD     = 8'h00;
  logic [7:0] c0;
  logic [7:0] c1;
  logic [6:0] c2;
  logic [2:0] c3;
  logic       cb0, cb1, cb2, cb3;

  int assertCount = 0;
  int failCount   = 0;

  logic [8:0]  expQ[$];
  logic [8:0]  nopQ[$];
  logic [29:0] chainQ[$];

  ctrl_pipe_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d), .q(q), .bubble(bubble)
  );

  ctrl_pipe_reg #(.WIDTH(8), .NOP_VAL(8'h80), .RST_VAL(8'h00)) dutNop (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d), .q(qNop), .bubble(bubbleNop)
  );

  ctrl_pipe_reg #(.WIDTH(8)) stage0 (
    .clk(clk), .reset(cReset), .en(cEn), .clr(cClr), .d(cD), .q(c0), .bubble(cb0)
  );
  ctrl_pipe_reg #(.WIDTH(8)) stage1 (
    .clk(clk), .reset(cReset), .en(cEn), .clr(cClr), .d(c0), .q(c1), .bubble(cb1)
  );
  ctrl_pipe_reg #(.WIDTH(7)) stage2 (
    .clk(clk), .reset(cReset), .en(cEn), .clr(cClr), .d(c1[6:0]), .q(c2), .bubble(cb2)
  );
  ctrl_pipe_reg #(.WIDTH(3)) stage3 (
    .clk(clk), .reset(cReset), .en(cEn), .clr(cClr), .d(c2[2:0]), .q(c3), .bubble(cb3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t v[5] = '{
      '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00},
      '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00},
      '{1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00},
      '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h00},
      '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00}
    };
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back({v[i].bub, v[i].q});
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL reset[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_pass_through();
    vec_t v[3] = '{
      '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5},
      '{1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C},
      '{1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 8'h81}
    };
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back({v[i].bub, v[i].q});
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL pass_through[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  // Includes a flush requested during a stall, which must be forgotten on re-enable.
  task automatic test_stall();
    vec_t v[8] = '{
      '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'hA5},
      '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'hA5},
      '{1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A},
      '{1'b0, 1'b1, 1'b0, 8'h34, 1'b0, 8'h34},
      '{1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 8'h34},
      '{1'b0, 1'b1, 1'b0, 8'h56, 1'b0, 8'h56}
    };
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back({v[i].bub, v[i].q});
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL stall[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_flush();
    vec_t v[3] = '{
      '{1'b0, 1'b1, 1'b0, 8'hE1, 1'b0, 8'hE1},
      '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 8'h00},
      '{1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 8'h12}
    };
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back({v[i].bub, v[i].q});
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL flush[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  // dutNop distinguishes RST_VAL (00) from NOP_VAL (80) so the priority order is visible.
  task automatic test_priority();
    vec_t v[4] = '{
      '{1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 8'h00},
      '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h00},
      '{1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 8'h80},
      '{1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 8'h77}
    };
    logic [8:0] nopExp[4] = '{9'h100, 9'h100, 9'h180, 9'h077};
    logic [8:0] mainExp[4] = '{9'h100, 9'h100, 9'h100, 9'h077};
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back(mainExp[i]);
      nopQ.push_back(nopExp[i]);
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL priority_main[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
      exp = nopQ.pop_front();
      got = {bubbleNop, qNop};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL priority_nop[%0d]: got bubble=%b q=%h, expected bubble=%b q=%h",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_x_handling();
    vec_t v[4] = '{
      '{1'b0, 1'b1, 1'b0, 8'b1x0x_1x01, 1'b0, 8'b1x0x_1x01},
      '{1'b0, 1'b1, 1'b1, 8'hxx,        1'b1, 8'h00},
      '{1'b0, 1'b1, 1'b0, 8'bx1x0_0x1x, 1'b0, 8'bx1x0_0x1x},
      '{1'b1, 1'b1, 1'b0, 8'hxx,        1'b1, 8'h00}
    };
    logic [8:0] got, exp;
    foreach (v[i]) begin
      reset = v[i].rst; en = v[i].en; clr = v[i].clr; d = v[i].d;
      expQ.push_back({v[i].bub, v[i].q});
      tick();
      exp = expQ.pop_front();
      got = {bubble, q};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL x_handling[%0d]: got bubble=%b q=%b, expected bubble=%b q=%b",
                 i, got[8], got[7:0], exp[8], exp[7:0]);
      end
    end
    reset = 1'b0;
  endtask

  // Expected word layout: {c0[7:0], c1[7:0], c2[6:0], c3[2:0], cb0, cb1, cb2, cb3}.
  task automatic test_chain();
    chainVec_t v[11] = '{
      '{1'b1, 1'b1, 1'b0, 8'hFF, {8'h00, 8'h00, 7'h00, 3'h0, 4'b1111}},
      '{1'b0, 1'b1, 1'b0, 8'hA3, {8'hA3, 8'h00, 7'h00, 3'h0, 4'b0000}},
      '{1'b0, 1'b1, 1'b0, 8'h00, {8'h00, 8'hA3, 7'h00, 3'h0, 4'b0000}},
      '{1'b0, 1'b0, 1'b0, 8'h55, {8'h00, 8'hA3, 7'h00, 3'h0, 4'b0000}},
      '{1'b0, 1'b0, 1'b1, 8'h55, {8'h00, 8'hA3, 7'h00, 3'h0, 4'b0000}},
      '{1'b0, 1'b1, 1'b0, 8'h00, {8'h00, 8'h00, 7'h23, 3'h0, 4'b0000}},
      '{1'b0, 1'b1, 1'b0, 8'hA3, {8'hA3, 8'h00, 7'h00, 3'h3, 4'b0000}},
      '{1'b0, 1'b1, 1'b0, 8'hA3, {8'hA3, 8'hA3, 7'h00, 3'h0, 4'b0000}},
      '{1'b0, 1'b1, 1'b0, 8'h00, {8'h00, 8'hA3, 7'h23, 3'h0, 4'b0000}},
      '{1'b0, 1'b0, 1'b1, 8'hFF, {8'h00, 8'hA3, 7'h23, 3'h0, 4'b0000}},
      '{1'b0, 1'b1, 1'b1, 8'hFF, {8'h00, 8'h00, 7'h00, 3'h0, 4'b1111}}
    };
    logic [29:0] got, exp;
    foreach (v[i]) begin
      cReset = v[i].rst; cEn = v[i].en; cClr = v[i].clr; cD = v[i].d;
      chainQ.push_back(v[i].exp);
      tick();
      exp = chainQ.pop_front();
      got = {c0, c1, c2, c3, cb0, cb1, cb2, cb3};
      assertCount++;
      if (got !== exp) begin
        failCount++;
        $display("[TB] FAIL chain[%0d]: got q=%h/%h/%h/%h bubbles=%b, expected q=%h/%h/%h/%h bubbles=%b",
                 i, got[29:22], got[21:14], got[13:7], got[6:4], got[3:0],
                 exp[29:22], exp[21:14], exp[13:7], exp[6:4], exp[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_stall();
    test_flush();
    test_priority();
    test_x_handling();
    test_chain();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
